// File: rtl/block_sweep_controller.sv
// Horizontal sweep sequencer for the stacking game's active block.
// Steps x at a programmable rate, bounces at the edges and offers drops via valid/ack.
module block_sweep_controller #(
    parameter int unsigned X_MAX      = 160,
    parameter logic [25:0] DELAY_STEP = 26'd500000,
    parameter logic [25:0] MIN_DELAY  = 26'd1000000,
    parameter logic [3:0]  LEVEL_MAX  = 4'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        drop,
    input  logic        drop_ack,
    input  logic        last,
    input  logic [25:0] base_delay,
    input  logic [7:0]  block_width,
    output logic [7:0]  x,
    output logic        dir,
    output logic        busy,
    output logic        drop_valid,
    output logic [7:0]  drop_x,
    output logic [3:0]  level
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_OFFER
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic        dir_q, dir_d;
    logic        drop_valid_q, drop_valid_d;
    logic [7:0]  drop_x_q, drop_x_d;
    logic [3:0]  level_q, level_d;
    logic [25:0] counter_q, counter_d;
    logic [25:0] cur_delay_q, cur_delay_d;
    logic [7:0]  width_q, width_d;

    logic [8:0]  x_max9;
    logic [8:0]  right_lim9;
    logic [7:0]  right_lim;
    logic [26:0] floor_thr;
    logic [25:0] delay_dec;
    logic [3:0]  level_inc;

    // Right limit is done in 9 bits so an oversized block clamps to 0 instead of wrapping.
    always_comb begin
        x_max9     = 9'(X_MAX);
        right_lim9 = x_max9 - {1'b0, width_q};
        if ({1'b0, width_q} >= x_max9) begin
            right_lim = '0;
        end else begin
            right_lim = right_lim9[7:0];
        end
    end

    always_comb begin
        floor_thr = {1'b0, MIN_DELAY} + {1'b0, DELAY_STEP};
        if ({1'b0, cur_delay_q} < floor_thr) begin
            delay_dec = MIN_DELAY;
        end else begin
            delay_dec = cur_delay_q - DELAY_STEP;
        end
        if (level_q >= LEVEL_MAX) begin
            level_inc = LEVEL_MAX;
        end else begin
            level_inc = level_q + 4'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        dir_d        = dir_q;
        drop_valid_d = drop_valid_q;
        drop_x_d     = drop_x_q;
        level_d      = level_q;
        counter_d    = counter_q;
        cur_delay_d  = cur_delay_q;
        width_d      = width_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_delay_d = base_delay;
                    counter_d   = base_delay;
                    x_d         = '0;
                    dir_d       = 1'b1;
                    level_d     = '0;
                    width_d     = block_width;
                    state_d     = ST_SWEEP;
                end
            end

            ST_SWEEP: begin
                // A drop wins over a coincident tick: the position is frozen as-is.
                if (drop) begin
                    drop_x_d     = x_q;
                    drop_valid_d = 1'b1;
                    state_d      = ST_OFFER;
                end else if (counter_q == '0) begin
                    counter_d = cur_delay_q;
                    if (dir_q) begin
                        if (x_q >= right_lim) begin
                            dir_d = 1'b0;
                            if (right_lim != '0) begin
                                x_d = x_q - 8'd1;
                            end
                        end else begin
                            x_d = x_q + 8'd1;
                        end
                    end else begin
                        if (x_q == '0) begin
                            dir_d = 1'b1;
                            if (right_lim != '0) begin
                                x_d = x_q + 8'd1;
                            end
                        end else begin
                            x_d = x_q - 8'd1;
                        end
                    end
                end else begin
                    counter_d = counter_q - 26'd1;
                end
            end

            ST_OFFER: begin
                if (drop_ack) begin
                    drop_valid_d = 1'b0;
                    level_d      = level_inc;
                    cur_delay_d  = delay_dec;
                    if (last) begin
                        state_d = ST_IDLE;
                    end else begin
                        x_d       = '0;
                        dir_d     = 1'b1;
                        counter_d = delay_dec;
                        width_d   = block_width;
                        state_d   = ST_SWEEP;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            dir_q        <= 1'b1;
            drop_valid_q <= 1'b0;
            drop_x_q     <= '0;
            level_q      <= '0;
            counter_q    <= '0;
            cur_delay_q  <= '0;
            width_q      <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            dir_q        <= dir_d;
            drop_valid_q <= drop_valid_d;
            drop_x_q     <= drop_x_d;
            level_q      <= level_d;
            counter_q    <= counter_d;
            cur_delay_q  <= cur_delay_d;
            width_q      <= width_d;
        end
    end

    assign x          = x_q;
    assign dir        = dir_q;
    assign busy       = (state_q != ST_IDLE);
    assign drop_valid = drop_valid_q;
    assign drop_x     = drop_x_q;
    assign level      = level_q;

endmodule

// File: doc/block_sweep_controller.md
Name: block_sweep_controller

Overview:
Sequences the horizontal sweep of the active block in the stacking game. An internal rate divider sets the step rate. On each step the x position moves one pixel and reverses direction at the playfield edges. A player drop freezes the position and hands it to the placement logic through a valid/ack handshake. Each accepted drop speeds up the sweep for the next level.

Parameters:
X_MAX, 160, playfield width in pixels; x ranges 0..X_MAX-1
DELAY_STEP, 26'd500000, cycles subtracted from the step delay per accepted drop
MIN_DELAY, 26'd1000000, floor for the step delay
LEVEL_MAX, 15, saturation value of level

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a game from IDLE
drop  in  1  single-cycle pulse; player drop request
drop_ack  in  1  placement logic has consumed drop_x
last  in  1  sampled with drop_ack; 1 = game ends after this drop
base_delay  in  26  initial step delay, latched on start
block_width  in  8  width of the moving block, latched on start and on each re-arm
x  out  8  current left-edge x of the moving block
dir  out  1  1 = moving right, 0 = moving left
busy  out  1  high in every state except IDLE
drop_valid  out  1  a drop position is being offered
drop_x  out  8  frozen x, valid while drop_valid is high
level  out  4  count of accepted drops, saturating

Behaviour:
- Reset, asynchronous, takes effect immediately in any state:
  - state=IDLE, x=0, dir=1, drop_valid=0, drop_x=0, level=0
  - internal counter=0, cur_delay=0, latched width=0
- States: IDLE, SWEEP, OFFER.
- IDLE:
  - drop and drop_ack are ignored.
  - On start: cur_delay<=base_delay, counter<=base_delay, x<=0, dir<=1, level<=0, latch block_width, go to SWEEP. Takes 1 cycle.
- SWEEP:
  - The counter decrements every cycle.
  - A tick occurs in the cycle where counter==0; the counter then reloads cur_delay. Tick period is cur_delay+1 cycles.
  - Right limit R = X_MAX - width, computed in 9 bits and clamped to 0 if negative.
  - On a tick with dir=1: if x>=R then dir<=0 and x<=x-1 (x held if R==0), else x<=x+1.
  - On a tick with dir=0: if x==0 then dir<=1 and x<=x+1 (held if R==0), else x<=x-1.
  - x always stays within 0..R.
  - drop has priority over a tick in the same cycle. x is not stepped, drop_x<=x, drop_valid<=1, go to OFFER. drop_valid rises 1 cycle after the drop pulse.
  - start is ignored.
- OFFER:
  - x, dir, counter and drop_x are frozen. drop_valid stays high until drop_ack is sampled high. drop is ignored.
  - On drop_ack:
    - drop_valid<=0
    - level<=min(level+1, LEVEL_MAX)
    - cur_delay<=MIN_DELAY if cur_delay < MIN_DELAY+DELAY_STEP, else cur_delay-DELAY_STEP (no underflow)
  - If last=1, go to IDLE; x and level keep their values.
  - Otherwise re-arm: x<=0, dir<=1, counter<=new cur_delay, re-latch block_width, go to SWEEP.
- drop_ack outside OFFER is ignored.
- base_delay < MIN_DELAY is accepted as is. The floor applies only when decrementing.

Test Plan:
- Reset then start, base_delay=3, block_width=150 (R=10): x steps every 4 cycles 0,1..10 then 9..0 then 1. dir toggles at x=10 and x=0. busy=1.
- drop on the cycle of a tick at x=5: next cycle drop_valid=1, drop_x=5, x stays 5. Hold drop_ack=0 for 20 cycles: all outputs frozen.
- Ack with last=0, cur_delay=1600000: drop_valid=0, level=1, cur_delay=1100000, x=0, dir=1. Next ack: cur_delay clamps to 1000000.
- Ack with last=1: state IDLE, busy=0. A following drop/ack is ignored. start restarts with level=0.
- block_width=200 (R=0): x stays 0 across 10 ticks, dir toggles, no wrap to 255.
- Assert reset mid-OFFER: drop_valid, x, level and busy drop to 0 immediately, without waiting for a clock edge.
